// File: rtl/reimu_bullet_pool_pkg.sv
// Shared defaults and the per-slot action encoding for the player shot engine.
package reimu_bullet_pool_pkg;

  localparam int N_BULLETS_MAX   = 8;
  localparam int DEF_N_BULLETS   = 4;
  localparam int DEF_COORD_W     = 10;
  localparam int DEF_FIRE_PERIOD = 16;
  localparam int DEF_ZONE1_Y     = 120;
  localparam int DEF_ZONE2_Y     = 240;
  localparam int DEF_SPD_TOP     = 1;
  localparam int DEF_SPD_MID     = 4;
  localparam int DEF_SPD_LOW     = 5;
  localparam int DEF_HIT_HW      = 15;
  localparam int DEF_HIT_HH      = 18;

  typedef enum logic [2:0] {
    SLOT_IDLE,
    SLOT_SPAWN,
    SLOT_HIT,
    SLOT_RETIRE,
    SLOT_MOVE
  } slot_act_t;

endpackage

// File: rtl/reimu_bullet_slot.sv
// One bullet slot: position/active state, zone speed select and target box compare.
module reimu_bullet_slot
  import reimu_bullet_pool_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int ZONE1_Y = DEF_ZONE1_Y,
  parameter int ZONE2_Y = DEF_ZONE2_Y,
  parameter int SPD_TOP = DEF_SPD_TOP,
  parameter int SPD_MID = DEF_SPD_MID,
  parameter int SPD_LOW = DEF_SPD_LOW,
  parameter int HIT_HW  = DEF_HIT_HW,
  parameter int HIT_HH  = DEF_HIT_HH
) (
  input  logic               clk_22,
  input  logic               rst_n,
  input  logic               spawn,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [COORD_W-1:0] spawn_y,
  input  logic [COORD_W-1:0] targetx,
  input  logic [COORD_W-1:0] targety,
  input  logic               target_alive,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               active,
  output logic               hit
);

  logic [COORD_W-1:0] x_reg, y_reg, x_next, y_next, spd;
  logic               active_reg, active_next, hit_reg, hit_next;
  logic signed [COORD_W:0] dx, dy, adx, ady;
  logic               in_box;
  slot_act_t          act;

  // One extra sign bit keeps far-apart coordinates from aliasing into the box.
  always_comb begin
    dx  = $signed({1'b0, x_reg}) - $signed({1'b0, targetx});
    dy  = $signed({1'b0, y_reg}) - $signed({1'b0, targety});
    adx = (dx < 0) ? -dx : dx;
    ady = (dy < 0) ? -dy : dy;
    in_box = target_alive
           && (adx <= $signed((COORD_W+1)'(HIT_HW)))
           && (ady <= $signed((COORD_W+1)'(HIT_HH)));
  end

  always_comb begin
    if (y_reg <= COORD_W'(ZONE1_Y))      spd = COORD_W'(SPD_TOP);
    else if (y_reg <= COORD_W'(ZONE2_Y)) spd = COORD_W'(SPD_MID);
    else                                 spd = COORD_W'(SPD_LOW);
  end

  always_comb begin
    act = SLOT_IDLE;
    if (active_reg) begin
      if (in_box)            act = SLOT_HIT;
      else if (y_reg <= spd) act = SLOT_RETIRE;
      else                   act = SLOT_MOVE;
    end else if (spawn) begin
      act = SLOT_SPAWN;
    end
  end

  always_comb begin
    x_next      = x_reg;
    y_next      = y_reg;
    active_next = active_reg;
    hit_next    = 1'b0;
    case (act)
      SLOT_SPAWN: begin
        x_next      = spawn_x;
        y_next      = spawn_y;
        active_next = 1'b1;
      end
      SLOT_HIT: begin
        active_next = 1'b0;
        hit_next    = 1'b1;
      end
      SLOT_RETIRE: active_next = 1'b0;
      SLOT_MOVE:   y_next = y_reg - spd;
      default: ;
    endcase
  end

  always_ff @(posedge clk_22 or negedge rst_n) begin
    if (!rst_n) begin
      x_reg      <= '0;
      y_reg      <= '0;
      active_reg <= 1'b0;
      hit_reg    <= 1'b0;
    end else begin
      x_reg      <= x_next;
      y_reg      <= y_next;
      active_reg <= active_next;
      hit_reg    <= hit_next;
    end
  end

  assign x      = x_reg;
  assign y      = y_reg;
  assign active = active_reg;
  assign hit    = hit_reg;

endmodule

// File: rtl/reimu_bullet_pool.sv
// Player shot engine: fire cooldown, lowest-free-slot allocation and N bullet slots.
module reimu_bullet_pool
  import reimu_bullet_pool_pkg::*;
#(
  parameter int N_BULLETS   = DEF_N_BULLETS,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int FIRE_PERIOD = DEF_FIRE_PERIOD,
  parameter int ZONE1_Y     = DEF_ZONE1_Y,
  parameter int ZONE2_Y     = DEF_ZONE2_Y,
  parameter int SPD_TOP     = DEF_SPD_TOP,
  parameter int SPD_MID     = DEF_SPD_MID,
  parameter int SPD_LOW     = DEF_SPD_LOW,
  parameter int HIT_HW      = DEF_HIT_HW,
  parameter int HIT_HH      = DEF_HIT_HH
) (
  input  logic                         clk_22,
  input  logic                         rst_n,
  input  logic                         fire_en,
  input  logic [COORD_W-1:0]           reimux,
  input  logic [COORD_W-1:0]           reimuy,
  input  logic [COORD_W-1:0]           targetx,
  input  logic [COORD_W-1:0]           targety,
  input  logic                         target_alive,
  output logic [N_BULLETS*COORD_W-1:0] bullet_x,
  output logic [N_BULLETS*COORD_W-1:0] bullet_y,
  output logic [N_BULLETS-1:0]         bullet_active,
  output logic [N_BULLETS-1:0]         hit_mask
);

  localparam int CD_W = $clog2(FIRE_PERIOD + 1);

  logic [CD_W-1:0]      cd_reg, cd_next;
  logic [N_BULLETS-1:0] free, lowest_free, spawn_vec, active_w, hit_w;
  logic                 can_fire;

  // Slots freed during this cycle still read as busy until the next one.
  assign free        = ~active_w;
  assign lowest_free = free & (~free + N_BULLETS'(1));
  assign can_fire    = (cd_reg == '0) && fire_en && (|free);
  assign spawn_vec   = can_fire ? lowest_free : '0;

  always_comb begin
    cd_next = cd_reg;
    if (cd_reg != '0)  cd_next = cd_reg - CD_W'(1);
    else if (can_fire) cd_next = CD_W'(FIRE_PERIOD - 1);
  end

  always_ff @(posedge clk_22 or negedge rst_n) begin
    if (!rst_n) cd_reg <= '0;
    else        cd_reg <= cd_next;
  end

  generate
    for (genvar gi = 0; gi < N_BULLETS; gi++) begin : g_slot
      reimu_bullet_slot #(
        .COORD_W(COORD_W), .ZONE1_Y(ZONE1_Y), .ZONE2_Y(ZONE2_Y),
        .SPD_TOP(SPD_TOP), .SPD_MID(SPD_MID), .SPD_LOW(SPD_LOW),
        .HIT_HW(HIT_HW),   .HIT_HH(HIT_HH)
      ) u_slot (
        .clk_22      (clk_22),
        .rst_n       (rst_n),
        .spawn       (spawn_vec[gi]),
        .spawn_x     (reimux),
        .spawn_y     (reimuy),
        .targetx     (targetx),
        .targety     (targety),
        .target_alive(target_alive),
        .x           (bullet_x[gi*COORD_W +: COORD_W]),
        .y           (bullet_y[gi*COORD_W +: COORD_W]),
        .active      (active_w[gi]),
        .hit         (hit_w[gi])
      );
    end
  endgenerate

  assign bullet_active = active_w;
  assign hit_mask      = hit_w;

endmodule

// File: tb/tb_reimu_bullet_pool.sv
// Directed bench for reimu_bullet_pool: default 4-slot instance plus a 1-slot, period-1 instance.
module tb_reimu_bullet_pool;

  logic        clk_22 = 1'b0;
  logic        rst_n;
  logic        fire_en, target_alive;
  logic [9:0]  reimux, reimuy, targetx, targety;
  logic [39:0] bullet_x, bullet_y;
  logic [3:0]  bullet_active, hit_mask;

  logic        fire_en1, target_alive1;
  logic [9:0]  reimux1, reimuy1, targetx1, targety1;
  logic [9:0]  bullet_x1, bullet_y1;
  logic [0:0]  bullet_active1, hit_mask1;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n;
  logic [3:0] hit_or;

  always #5 clk_22 = ~clk_22;

  reimu_bullet_pool d0 (
    .clk_22(clk_22), .rst_n(rst_n), .fire_en(fire_en),
    .reimux(reimux), .reimuy(reimuy), .targetx(targetx), .targety(targety),
    .target_alive(target_alive), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_active(bullet_active), .hit_mask(hit_mask)
  );

  reimu_bullet_pool #(.N_BULLETS(1), .FIRE_PERIOD(1)) d1 (
    .clk_22(clk_22), .rst_n(rst_n), .fire_en(fire_en1),
    .reimux(reimux1), .reimuy(reimuy1), .targetx(targetx1), .targety(targety1),
    .target_alive(target_alive1), .bullet_x(bullet_x1), .bullet_y(bullet_y1),
    .bullet_active(bullet_active1), .hit_mask(hit_mask1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic logic [9:0] by(input int i);
    return bullet_y[i*10 +: 10];
  endfunction

  function automatic logic [9:0] bx(input int i);
    return bullet_x[i*10 +: 10];
  endfunction

  task automatic tick();
    @(posedge clk_22);
    #1;
    edge_n++;
  endtask

  task automatic go(input int k);
    while (edge_n < k) tick();
  endtask

  task automatic do_reset();
    fire_en  = 1'b0;
    fire_en1 = 1'b0;
    rst_n    = 1'b0;
    #2;
    rst_n    = 1'b1;
    tick();
  endtask

  task automatic spawn_one(input logic [9:0] sx, input logic [9:0] sy);
    reimux  = sx;
    reimuy  = sy;
    fire_en = 1'b1;
    tick();
    fire_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fire_en = 1'b0; target_alive = 1'b0;
    reimux = '0; reimuy = '0; targetx = '0; targety = '0;
    fire_en1 = 1'b0; target_alive1 = 1'b0;
    reimux1 = '0; reimuy1 = '0; targetx1 = '0; targety1 = '0;
    edge_n = 0;
    @(posedge clk_22); #1;
    check("rst_active", 32'(bullet_active), 0);
    check("rst_hit", 32'(hit_mask), 0);
    check("rst_y0", 32'(by(0)), 0);
    do_reset();

    // Held fire from y=400 with no target: four spawns, then wait for a free slot
    reimux = 10'd100; reimuy = 10'd400; target_alive = 1'b0; fire_en = 1'b1;
    edge_n = -1;
    go(0);   check("t2_e0_active", 32'(bullet_active), 4'b0001);
             check("t2_e0_y0", 32'(by(0)), 400);
             check("t2_e0_x0", 32'(bx(0)), 100);
    go(1);   check("t2_e1_y0", 32'(by(0)), 395);
    go(15);  check("t2_e15_active", 32'(bullet_active), 4'b0001);
    go(16);  check("t2_e16_active", 32'(bullet_active), 4'b0011);
             check("t2_e16_y1", 32'(by(1)), 400);
             check("t2_e16_y0", 32'(by(0)), 320);
    go(32);  check("t2_e32_y0", 32'(by(0)), 240);
             check("t2_e32_active", 32'(bullet_active), 4'b0111);
    go(33);  check("t2_e33_y0", 32'(by(0)), 236);
    go(48);  check("t2_e48_active", 32'(bullet_active), 4'b1111);
    go(62);  check("t2_e62_y0", 32'(by(0)), 120);
    go(63);  check("t2_e63_y0", 32'(by(0)), 119);
    go(181); check("t2_e181_y0", 32'(by(0)), 1);
             check("t2_e181_active", 32'(bullet_active), 4'b1111);
    go(182); check("t2_e182_active", 32'(bullet_active), 4'b1110);
             check("t2_e182_y0", 32'(by(0)), 1);
    go(183); check("t2_e183_active", 32'(bullet_active), 4'b1111);
             check("t2_e183_y0", 32'(by(0)), 400);

    // Asynchronous reset mid-flight
    rst_n = 1'b0;
    #1;
    check("t1_async_active", 32'(bullet_active), 0);
    check("t1_async_x0", 32'(bx(0)), 0);
    check("t1_async_y0", 32'(by(0)), 0);
    check("t1_async_hit", 32'(hit_mask), 0);
    rst_n = 1'b1;
    fire_en = 1'b0;
    tick();

    // Single bullet against live target at (200,250)
    targetx = 10'd200; targety = 10'd250; target_alive = 1'b1;
    spawn_one(10'd200, 10'd300);
    check("t3_spawn_y", 32'(by(0)), 300);
    repeat (7) tick();
    check("t3_pre_hit", 32'(hit_mask), 0);
    check("t3_pre_y", 32'(by(0)), 265);
    check("t3_pre_active", 32'(bullet_active), 4'b0001);
    tick();
    check("t3_hit", 32'(hit_mask), 4'b0001);
    check("t3_hit_active", 32'(bullet_active), 0);
    check("t3_hit_y", 32'(by(0)), 265);
    tick();
    check("t3_hit_pulse_end", 32'(hit_mask), 0);

    // Same trajectory with the target dead flies to the top
    target_alive = 1'b0;
    repeat (10) tick();
    spawn_one(10'd200, 10'd300);
    hit_or = '0;
    for (int i = 0; i < 161; i++) begin
      tick();
      hit_or |= hit_mask;
      if (i == 7) check("t3_dead_y260", 32'(by(0)), 260);
    end
    check("t3_dead_top_y", 32'(by(0)), 1);
    check("t3_dead_top_active", 32'(bullet_active), 4'b0001);
    tick();
    check("t3_dead_retired", 32'(bullet_active), 0);
    check("t3_dead_no_hit", 32'(hit_or), 0);

    // Two slots enter the box together
    do_reset();
    targetx = 10'd105; targety = 10'd250; target_alive = 1'b1;
    spawn_one(10'd100, 10'd400);
    repeat (15) tick();
    spawn_one(10'd110, 10'd320);
    check("t4_pair_active", 32'(bullet_active), 4'b0011);
    check("t4_pair_y0", 32'(by(0)), 320);
    check("t4_pair_y1", 32'(by(1)), 320);
    repeat (11) tick();
    check("t4_pre_hit", 32'(hit_mask), 0);
    check("t4_pre_y1", 32'(by(1)), 265);
    tick();
    check("t4_hit", 32'(hit_mask), 4'b0011);
    check("t4_hit_active", 32'(bullet_active), 0);
    tick();
    check("t4_pulse_end", 32'(hit_mask), 0);

    // Boundaries: spawn at y=0, spawn inside box, box edge, no coordinate wrap
    do_reset();
    target_alive = 1'b0;
    spawn_one(10'd50, 10'd0);
    check("t5_y0_active", 32'(bullet_active), 4'b0001);
    tick();
    check("t5_y0_retired", 32'(bullet_active), 0);
    check("t5_y0_nohit", 32'(hit_mask), 0);

    do_reset();
    targetx = 10'd200; targety = 10'd250; target_alive = 1'b1;
    spawn_one(10'd215, 10'd250);
    check("t5_inbox_active", 32'(bullet_active), 4'b0001);
    tick();
    check("t5_edge15_hit", 32'(hit_mask), 4'b0001);

    do_reset();
    spawn_one(10'd216, 10'd250);
    tick();
    check("t5_edge16_nohit", 32'(hit_mask), 0);
    check("t5_edge16_y", 32'(by(0)), 245);

    do_reset();
    targetx = 10'd5; targety = 10'd300;
    spawn_one(10'd1000, 10'd300);
    repeat (2) tick();
    check("t5_far1000_nohit", 32'(hit_mask), 0);
    check("t5_far1000_active", 32'(bullet_active), 4'b0001);

    do_reset();
    spawn_one(10'd1020, 10'd300);
    tick();
    check("t5_far1020_nohit", 32'(hit_mask), 0);

    // One slot, period 1: respawn the cycle after retire
    do_reset();
    target_alive = 1'b0;
    fire_en1 = 1'b1; reimux1 = 10'd7; reimuy1 = 10'd3; target_alive1 = 1'b0;
    tick(); check("t6_e0_active", 32'(bullet_active1), 1); check("t6_e0_y", 32'(bullet_y1), 3);
    tick(); check("t6_e1_active", 32'(bullet_active1), 1); check("t6_e1_y", 32'(bullet_y1), 2);
    tick(); check("t6_e2_active", 32'(bullet_active1), 1); check("t6_e2_y", 32'(bullet_y1), 1);
    tick(); check("t6_e3_active", 32'(bullet_active1), 0); check("t6_e3_y", 32'(bullet_y1), 1);
    tick(); check("t6_e4_active", 32'(bullet_active1), 1); check("t6_e4_y", 32'(bullet_y1), 3);
    check("t6_e4_x", 32'(bullet_x1), 7);
    fire_en1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
